// File: rtl/hazard_scoreboard_if.sv
// Decode/writeback/flush bundle for the hazard scoreboard.
// The master side drives issue, retire, flush and query; the slave side returns bubbles and error flags.
interface hazard_scoreboard_if;
   logic       issue_valid;
   logic       issue_wen;
   logic [4:0] issue_rd;
   logic       issue_csr;
   logic       wb_valid;
   logic [4:0] wb_rd;
   logic       wb_csr;
   logic       flush;
   logic [4:0] rs1;
   logic [4:0] rs2;
   logic       bubble1;
   logic       bubble2;
   logic       bubble3;
   logic       overflow_err;
   logic       underflow_err;

   modport master (
      output issue_valid, issue_wen, issue_rd, issue_csr,
      output wb_valid, wb_rd, wb_csr, flush, rs1, rs2,
      input  bubble1, bubble2, bubble3, overflow_err, underflow_err
   );

   modport slave (
      input  issue_valid, issue_wen, issue_rd, issue_csr,
      input  wb_valid, wb_rd, wb_csr, flush, rs1, rs2,
      output bubble1, bubble2, bubble3, overflow_err, underflow_err
   );
endinterface

// File: rtl/hazard_scoreboard.sv
// Pending-write scoreboard: saturating 2-bit counts per GPR x1..x31 plus one CSR count.
// Optional macro SCOREBOARD_WB_BYPASS_EN hides a bubble when the last pending write retires this cycle.
module hazard_scoreboard (
   input logic          clk,
   input logic          reset_n,
   hazard_scoreboard_if.slave bus
);

   typedef struct packed {
      logic [1:0] cnt;
      logic       ovf;
      logic       unf;
   } upd_t;

   function automatic upd_t f_update(input logic [1:0] cnt, input logic inc, input logic dec);
      upd_t res;
      res.cnt = cnt;
      res.ovf = 1'b0;
      res.unf = 1'b0;
      if (inc && !dec) begin
         if (cnt == 2'd3) res.ovf = 1'b1;
         else             res.cnt = cnt + 2'd1;
      end else if (dec && !inc) begin
         if (cnt == 2'd0) res.unf = 1'b1;
         else             res.cnt = cnt - 2'd1;
      end else begin
         res.cnt = cnt;
      end
      return res;
   endfunction

   // Entry 0 is held at zero so x0 lookups are always clean.
   logic [31:0][1:0] r_cnt;
   logic [1:0]       r_csr_cnt;
   logic             r_ovf;
   logic             r_unf;

   logic [31:0][1:0] w_cnt_nxt;
   logic [1:0]       w_csr_nxt;
   logic             w_ovf_ev;
   logic             w_unf_ev;
   upd_t             w_csr_res;

   // Next-state counts and error events for every tracked register.
   always_comb begin
      w_cnt_nxt = r_cnt;
      w_csr_nxt = r_csr_cnt;
      w_ovf_ev  = 1'b0;
      w_unf_ev  = 1'b0;
      w_csr_res = f_update(r_csr_cnt, bus.issue_valid & bus.issue_csr, bus.wb_csr);
      w_cnt_nxt[0] = 2'd0;
      for (int i = 1; i < 32; i++) begin
         upd_t w_res;
         w_res = f_update(r_cnt[i],
                          bus.issue_valid & bus.issue_wen & (bus.issue_rd == 5'(i)),
                          bus.wb_valid & (bus.wb_rd == 5'(i)));
         w_cnt_nxt[i] = w_res.cnt;
         w_ovf_ev     = w_ovf_ev | w_res.ovf;
         w_unf_ev     = w_unf_ev | w_res.unf;
      end
      w_csr_nxt = w_csr_res.cnt;
      w_ovf_ev  = w_ovf_ev | w_csr_res.ovf;
      w_unf_ev  = w_unf_ev | w_csr_res.unf;
      if (bus.flush) begin
         w_cnt_nxt = '0;
         w_csr_nxt = 2'd0;
         w_ovf_ev  = 1'b0;
         w_unf_ev  = 1'b0;
      end else begin
         w_csr_nxt = w_csr_res.cnt;
      end
   end

   // Count and sticky error registers.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_cnt     <= '0;
         r_csr_cnt <= 2'd0;
         r_ovf     <= 1'b0;
         r_unf     <= 1'b0;
      end else begin
         r_cnt     <= w_cnt_nxt;
         r_csr_cnt <= w_csr_nxt;
         r_ovf     <= r_ovf | w_ovf_ev;
         r_unf     <= r_unf | w_unf_ev;
      end
   end

   logic w_byp1;
   logic w_byp2;
   logic w_byp3;

`ifdef SCOREBOARD_WB_BYPASS_EN
   assign w_byp1 = (r_cnt[bus.rs1] == 2'd1) & bus.wb_valid & (bus.wb_rd == bus.rs1) & ~bus.flush;
   assign w_byp2 = (r_cnt[bus.rs2] == 2'd1) & bus.wb_valid & (bus.wb_rd == bus.rs2) & ~bus.flush;
   assign w_byp3 = (r_csr_cnt == 2'd1) & bus.wb_csr & ~bus.flush;
`else
   assign w_byp1 = 1'b0;
   assign w_byp2 = 1'b0;
   assign w_byp3 = 1'b0;
`endif

   // Bubbles look only at registered counts, so a same-cycle issue is invisible until next cycle.
   assign bus.bubble1       = (bus.rs1 != 5'd0) & (r_cnt[bus.rs1] != 2'd0) & ~w_byp1;
   assign bus.bubble2       = (bus.rs2 != 5'd0) & (r_cnt[bus.rs2] != 2'd0) & ~w_byp2;
   assign bus.bubble3       = (r_csr_cnt != 2'd0) & ~w_byp3;
   assign bus.overflow_err  = r_ovf;
   assign bus.underflow_err = r_unf;

endmodule

// File: tb/tb_hazard_scoreboard.sv
// Directed self-checking bench for hazard_scoreboard.
module tb_hazard_scoreboard;
   logic clk;
   logic reset_n;
   int   tests;
   int   fails;

   hazard_scoreboard_if bus ();

   hazard_scoreboard dut (
      .clk     (clk),
      .reset_n (reset_n),
      .bus     (bus.slave)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic idle();
      bus.issue_valid = 1'b0;
      bus.issue_wen   = 1'b0;
      bus.issue_rd    = 5'd0;
      bus.issue_csr   = 1'b0;
      bus.wb_valid    = 1'b0;
      bus.wb_rd       = 5'd0;
      bus.wb_csr      = 1'b0;
      bus.flush       = 1'b0;
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      idle();
      bus.rs1 = 5'd0;
      bus.rs2 = 5'd0;
      reset_n = 1'b0;
      tick();
      tick();
      reset_n = 1'b1;
      tick();
   endtask

   task automatic issue_gpr(input logic [4:0] rd);
      bus.issue_valid = 1'b1;
      bus.issue_wen   = 1'b1;
      bus.issue_rd    = rd;
   endtask

   task automatic test_reset();
      do_reset();
      bus.rs1 = 5'd5;
      bus.rs2 = 5'd7;
      #1;
      tests++;
      if ({bus.bubble1, bus.bubble2, bus.bubble3, bus.overflow_err, bus.underflow_err} !== 5'b00000) begin
         fails++;
         $display("FAIL reset_outputs: got %b want 00000",
                  {bus.bubble1, bus.bubble2, bus.bubble3, bus.overflow_err, bus.underflow_err});
      end
   endtask

   task automatic test_issue_retire();
      logic exp_c3;
      do_reset();
      bus.rs1 = 5'd5;
      issue_gpr(5'd5);
      #1;
      tests++;
      if (bus.bubble1 !== 1'b0) begin
         fails++; $display("FAIL issue_cycle0_bubble1: got %b want 0", bus.bubble1);
      end
      tick();
      idle();
      #1;
      tests++;
      if (bus.bubble1 !== 1'b1) begin
         fails++; $display("FAIL issue_cycle1_bubble1: got %b want 1", bus.bubble1);
      end
      tick();
      tick();
      bus.wb_valid = 1'b1;
      bus.wb_rd    = 5'd5;
      #1;
`ifdef SCOREBOARD_WB_BYPASS_EN
      exp_c3 = 1'b0;
`else
      exp_c3 = 1'b1;
`endif
      tests++;
      if (bus.bubble1 !== exp_c3) begin
         fails++; $display("FAIL wb_cycle3_bubble1: got %b want %b", bus.bubble1, exp_c3);
      end
      tick();
      idle();
      #1;
      tests++;
      if (bus.bubble1 !== 1'b0) begin
         fails++; $display("FAIL wb_cycle4_bubble1: got %b want 0", bus.bubble1);
      end
   endtask

   task automatic test_overflow();
      do_reset();
      bus.rs2 = 5'd7;
      for (int i = 0; i < 3; i++) begin
         issue_gpr(5'd7);
         tick();
      end
      idle();
      #1;
      tests++;
      if ({bus.bubble2, bus.overflow_err} !== 2'b10) begin
         fails++; $display("FAIL ovf_three_issues: got %b want 10", {bus.bubble2, bus.overflow_err});
      end
      issue_gpr(5'd7);
      tick();
      idle();
      #1;
      tests++;
      if (bus.overflow_err !== 1'b1) begin
         fails++; $display("FAIL ovf_fourth_issue: got %b want 1", bus.overflow_err);
      end
      for (int i = 0; i < 3; i++) begin
         bus.wb_valid = 1'b1;
         bus.wb_rd    = 5'd7;
         tick();
         idle();
         #1;
         tests++;
         if (bus.bubble2 !== ((i == 2) ? 1'b0 : 1'b1)) begin
            fails++; $display("FAIL ovf_retire_%0d_bubble2: got %b want %b", i, bus.bubble2, (i == 2) ? 1'b0 : 1'b1);
         end
      end
      tests++;
      if ({bus.overflow_err, bus.underflow_err} !== 2'b10) begin
         fails++; $display("FAIL ovf_sticky_flags: got %b want 10", {bus.overflow_err, bus.underflow_err});
      end
   endtask

   task automatic test_x0();
      do_reset();
      bus.rs1 = 5'd0;
      bus.rs2 = 5'd0;
      for (int i = 0; i < 4; i++) begin
         issue_gpr(5'd0);
         bus.wb_valid = 1'b1;
         bus.wb_rd    = 5'd0;
         tick();
      end
      idle();
      bus.wb_valid = 1'b1;
      bus.wb_rd    = 5'd0;
      tick();
      idle();
      #1;
      tests++;
      if ({bus.bubble1, bus.bubble2, bus.overflow_err, bus.underflow_err} !== 4'b0000) begin
         fails++; $display("FAIL x0_ignored: got %b want 0000",
                           {bus.bubble1, bus.bubble2, bus.overflow_err, bus.underflow_err});
      end
   endtask

   task automatic test_same_cycle();
      do_reset();
      bus.rs2 = 5'd9;
      issue_gpr(5'd9);
      tick();
      issue_gpr(5'd9);
      bus.wb_valid = 1'b1;
      bus.wb_rd    = 5'd9;
      tick();
      idle();
      #1;
      tests++;
      if (bus.bubble2 !== 1'b1) begin
         fails++; $display("FAIL same_cycle_bubble2: got %b want 1", bus.bubble2);
      end
      bus.wb_valid = 1'b1;
      bus.wb_rd    = 5'd9;
      tick();
      idle();
      #1;
      tests++;
      if ({bus.bubble2, bus.overflow_err, bus.underflow_err} !== 3'b000) begin
         fails++; $display("FAIL same_cycle_count1: got %b want 000",
                           {bus.bubble2, bus.overflow_err, bus.underflow_err});
      end
   endtask

   task automatic test_csr();
      do_reset();
      for (int i = 0; i < 4; i++) begin
         bus.issue_valid = 1'b1;
         bus.issue_csr   = 1'b1;
         tick();
      end
      idle();
      #1;
      tests++;
      if ({bus.bubble3, bus.overflow_err} !== 2'b11) begin
         fails++; $display("FAIL csr_overflow: got %b want 11", {bus.bubble3, bus.overflow_err});
      end
      for (int i = 0; i < 3; i++) begin
         bus.wb_csr = 1'b1;
         tick();
      end
      idle();
      #1;
      tests++;
      if ({bus.bubble3, bus.underflow_err} !== 2'b00) begin
         fails++; $display("FAIL csr_drain: got %b want 00", {bus.bubble3, bus.underflow_err});
      end
   endtask

   task automatic test_flush_underflow();
      do_reset();
      bus.rs1 = 5'd3;
      bus.rs2 = 5'd4;
      issue_gpr(5'd3);
      tick();
      issue_gpr(5'd4);
      bus.issue_csr = 1'b1;
      tick();
      idle();
      #1;
      tests++;
      if ({bus.bubble1, bus.bubble2, bus.bubble3} !== 3'b111) begin
         fails++; $display("FAIL flush_pre_bubbles: got %b want 111", {bus.bubble1, bus.bubble2, bus.bubble3});
      end
      bus.flush = 1'b1;
      issue_gpr(5'd3);
      bus.wb_valid = 1'b1;
      bus.wb_rd    = 5'd5;
      tick();
      idle();
      #1;
      tests++;
      if ({bus.bubble1, bus.bubble2, bus.bubble3, bus.overflow_err, bus.underflow_err} !== 5'b00000) begin
         fails++; $display("FAIL flush_clears: got %b want 00000",
                           {bus.bubble1, bus.bubble2, bus.bubble3, bus.overflow_err, bus.underflow_err});
      end
      bus.wb_valid = 1'b1;
      bus.wb_rd    = 5'd3;
      tick();
      idle();
      #1;
      tests++;
      if ({bus.underflow_err, bus.overflow_err} !== 2'b10) begin
         fails++; $display("FAIL flush_then_underflow: got %b want 10", {bus.underflow_err, bus.overflow_err});
      end
   endtask

   task automatic test_async_reset();
      do_reset();
      bus.rs1 = 5'd3;
      for (int i = 0; i < 4; i++) begin
         issue_gpr(5'd3);
         bus.issue_csr = 1'b1;
         tick();
      end
      idle();
      #1;
      tests++;
      if ({bus.bubble1, bus.bubble3, bus.overflow_err} !== 3'b111) begin
         fails++; $display("FAIL async_pre_state: got %b want 111", {bus.bubble1, bus.bubble3, bus.overflow_err});
      end
      #1;
      reset_n = 1'b0;
      #1;
      tests++;
      if ({bus.bubble1, bus.bubble2, bus.bubble3, bus.overflow_err, bus.underflow_err} !== 5'b00000) begin
         fails++; $display("FAIL async_reset_immediate: got %b want 00000",
                           {bus.bubble1, bus.bubble2, bus.bubble3, bus.overflow_err, bus.underflow_err});
      end
      tick();
      reset_n = 1'b1;
      issue_gpr(5'd3);
      tick();
      idle();
      #1;
      tests++;
      if ({bus.bubble1, bus.bubble3, bus.overflow_err} !== 3'b100) begin
         fails++; $display("FAIL async_resume: got %b want 100", {bus.bubble1, bus.bubble3, bus.overflow_err});
      end
   endtask

   initial begin
      tests = 0;
      fails = 0;
      idle();
      bus.rs1 = 5'd0;
      bus.rs2 = 5'd0;
      reset_n = 1'b0;
      test_reset();
      test_issue_retire();
      test_overflow();
      test_x0();
      test_same_cycle();
      test_csr();
      test_flush_underflow();
      test_async_reset();
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

   initial begin
      #100000;
      $display("FAIL timeout: simulation exceeded time limit");
      $fatal(1, "timeout");
   end
endmodule

// File: doc/hazard_scoreboard.md
HAZARD_SCOREBOARD -- requirements
Module: hazard_scoreboard

Interface
REQ-001 SHALL have port clk  input  1  sole clock, all state updates on rising edge.
REQ-002 SHALL have port reset_n  input  1  asynchronous active-low reset.
REQ-003 SHALL have port issue_valid  input  1  decode issues an instruction this cycle.
REQ-004 SHALL have port issue_wen  input  1  issued instruction writes a GPR.
REQ-005 SHALL have port issue_rd  input  5  destination GPR of issued instruction.
REQ-006 SHALL have port issue_csr  input  1  issued instruction writes a CSR.
REQ-007 SHALL have port wb_valid  input  1  writeback retires a GPR write this cycle.
REQ-008 SHALL have port wb_rd  input  5  GPR retired by writeback.
REQ-009 SHALL have port wb_csr  input  1  writeback retires a CSR write this cycle.
REQ-010 SHALL have port flush  input  1  pipeline flush; drop all pending writes.
REQ-011 SHALL have ports rs1, rs2  input  5 each  source GPRs queried by decode.
REQ-012 SHALL have ports bubble1, bubble2  output  1 each  rs1 / rs2 has a pending write.
REQ-013 SHALL have port bubble3  output  1  a CSR write is pending.
REQ-014 SHALL have ports overflow_err, underflow_err  output  1 each  sticky bookkeeping errors.

Function
REQ-015 SHALL keep a 2-bit pending count per GPR x1..x31 and one 2-bit CSR pending count.
REQ-016 SHALL increment count[issue_rd] on issue_valid & issue_wen & issue_rd!=0.
REQ-017 SHALL decrement count[wb_rd] on wb_valid & wb_rd!=0.
REQ-018 SHALL leave a count unchanged when increment and decrement hit the same register in one cycle.
REQ-019 SHALL saturate at 3: increment at 3 with no decrement keeps 3 and sets overflow_err.
REQ-020 SHALL floor at 0: decrement at 0 with no increment keeps 0 and sets underflow_err.
REQ-021 SHALL treat x0 as never pending; writes to x0 on either port are ignored, no error.
REQ-022 SHALL apply REQ-016..REQ-020 identically to the CSR count via issue_valid & issue_csr and wb_csr.
REQ-023 SHALL, on flush, clear every count to 0 next edge; same-cycle issue/retire ignored; no error flags raised by that cycle.
REQ-024 SHALL drive bubble1 = (rs1!=0) & count[rs1]!=0, bubble2 likewise for rs2, bubble3 = CSR count!=0; combinational from current state and query, zero latency.
REQ-025 SHALL NOT let a same-cycle issue affect bubble outputs; new pending state is visible the following cycle.
REQ-026 SHALL hold overflow_err/underflow_err at 1 once set until reset.

Reset
REQ-027 SHALL, on reset_n low, asynchronously clear all counts and both error flags; bubble1..3 read 0.
REQ-028 SHALL resume normal updates on the first rising clk edge after reset_n deasserts; reset mid-operation discards all pending state.

Configuration
REQ-029 SHALL honour macro SCOREBOARD_WB_BYPASS_EN: when defined, a bubble output is 0 if the queried register's count is 1 and the same register retires this cycle (wb_valid & wb_rd match, or wb_csr for bubble3) with no flush; when undefined, bubble outputs reflect registered counts only.

Verification
REQ-030 SHALL cover: issue x5 cycle 0, rs1=5 -> bubble1=0 cycle 0, 1 cycle 1; wb x5 cycle 3 -> bubble1=0 cycle 4 (cycle 3 with SCOREBOARD_WB_BYPASS_EN).
REQ-031 SHALL cover: issue x7 three times, then fourth issue -> count stays 3, overflow_err=1; three retires -> bubble for x7 clears after third.
REQ-032 SHALL cover: issue x0 and retire x0, rs1=rs2=0 -> bubble1=bubble2=0, no error flags.
REQ-033 SHALL cover: issue x9 and wb x9 in same cycle with count 1 -> count remains 1, bubble2 (rs2=9) stays 1.
REQ-034 SHALL cover: pending x3, x4, CSR, then flush -> next cycle all bubbles 0; retire x3 after -> underflow_err=1.
REQ-035 SHALL cover: reset_n low asynchronously mid-cycle with pending regs and error set -> all outputs 0 immediately, before next clk edge.
